// File: rtl/sa_tile_result_drain_if.sv
// Row-stream bus from the result drain to the C writeback sink.
// The master drives row beats and the slave returns row_ready.
interface sa_tile_result_drain_if #(
    parameter int M  = 8,
    parameter int N  = 8,
    parameter int DW = 32
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    logic          row_valid;
    logic          row_ready;
    logic [N*DW-1:0] row_data;
    logic [IW-1:0] row_idx;
    logic          row_last;

    modport master (
        output row_valid,
        output row_data,
        output row_idx,
        output row_last,
        input  row_ready
    );

    modport slave (
        input  row_valid,
        input  row_data,
        input  row_idx,
        input  row_last,
        output row_ready
    );
endinterface

// File: rtl/sa_tile_result_drain.sv
// Captures a finished MxN tile from the systolic array on the rising edge of "all valid" and
// streams it one row per beat. Optional macro SA_DRAIN_RELU_EN zeroes sign-set words on output.
module sa_tile_result_drain #(
    parameter int M  = 8,
    parameter int N  = 8,
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [M*N*DW-1:0]     c_out_flat,
    input  logic [M*N-1:0]        c_valid_flat,
    sa_tile_result_drain_if.master bus,
    output logic                  drain_busy,
    output logic                  drain_done,
    output logic                  overrun_err,
    input  logic                  err_clr,
    output logic [15:0]           tiles_drained
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int RW = N * DW;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic            all_vld_q, all_vld_d;
    logic [RW-1:0]   buf_q [M];
    logic [RW-1:0]   buf_d [M];
    logic [IW-1:0]   row_idx_q, row_idx_d;
    logic            row_valid_q, row_valid_d;
    logic            row_last_q, row_last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            overrun_q, overrun_d;
    logic [15:0]     tiles_q, tiles_d;

    logic            tile_edge;
    logic            accept;
    logic [RW-1:0]   row_word;

`ifdef SA_DRAIN_RELU_EN
    function automatic logic [DW-1:0] relu_word(input logic [DW-1:0] w);
        return w[DW-1] ? '0 : w;
    endfunction
`endif

    always_comb begin
        all_vld_d   = &c_valid_flat;
        tile_edge   = all_vld_d & ~all_vld_q;
        accept      = row_valid_q & bus.row_ready;

        state_d     = state_q;
        buf_d       = buf_q;
        row_idx_d   = row_idx_q;
        row_valid_d = row_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tiles_d     = tiles_q;

        case (state_q)
            IDLE: begin
                if (tile_edge) begin
                    for (int i = 0; i < M; i++) begin
                        buf_d[i] = c_out_flat[i*RW +: RW];
                    end
                    row_idx_d   = '0;
                    row_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    if (row_idx_q == IW'(M - 1)) begin
                        row_idx_d   = '0;
                        row_valid_d = 1'b0;
                        done_d      = 1'b1;
                        tiles_d     = tiles_q + 16'd1;
                        state_d     = DONE;
                    end else begin
                        row_idx_d = row_idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        row_last_d = row_valid_d && (row_idx_d == IW'(M - 1));

        // A tile arriving outside IDLE (including the DONE cycle) is dropped; set beats clear.
        if (tile_edge && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            all_vld_q   <= 1'b0;
            buf_q       <= '{default: '0};
            row_idx_q   <= '0;
            row_valid_q <= 1'b0;
            row_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            tiles_q     <= '0;
        end else begin
            state_q     <= state_d;
            all_vld_q   <= all_vld_d;
            buf_q       <= buf_d;
            row_idx_q   <= row_idx_d;
            row_valid_q <= row_valid_d;
            row_last_q  <= row_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            tiles_q     <= tiles_d;
        end
    end

    // Output mux: data is forced to zero whenever no beat is offered.
    always_comb begin
        row_word = '0;
        if (row_valid_q) begin
            row_word = buf_q[row_idx_q];
        end
`ifdef SA_DRAIN_RELU_EN
        for (int j = 0; j < N; j++) begin
            row_word[j*DW +: DW] = relu_word(row_word[j*DW +: DW]);
        end
`endif
    end

    assign bus.row_valid  = row_valid_q;
    assign bus.row_data   = row_word;
    assign bus.row_idx    = row_idx_q;
    assign bus.row_last   = row_last_q;
    assign drain_busy     = busy_q;
    assign drain_done     = done_q;
    assign overrun_err    = overrun_q;
    assign tiles_drained  = tiles_q;

endmodule

// File: tb/tb_sa_tile_result_drain.sv
// Scoreboard bench for sa_tile_result_drain: stimulus queues expected row beats,
// a negedge monitor pops and compares every accepted beat.
module tb_sa_tile_result_drain;
    localparam int M  = 8;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int W  = N * DW;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               err_clr = 1'b0;
    logic [M*N*DW-1:0]  c_out_flat = '0;
    logic [M*N-1:0]     c_valid_flat = '0;
    logic               drain_busy;
    logic               drain_done;
    logic               overrun_err;
    logic [15:0]        tiles_drained;

    sa_tile_result_drain_if #(.M(M), .N(N), .DW(DW)) bus ();

    sa_tile_result_drain #(.M(M), .N(N), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .c_out_flat    (c_out_flat),
        .c_valid_flat  (c_valid_flat),
        .bus           (bus),
        .drain_busy    (drain_busy),
        .drain_done    (drain_done),
        .overrun_err   (overrun_err),
        .err_clr       (err_clr),
        .tiles_drained (tiles_drained)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           idx;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_row(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] c_word(input int t, input int i, input int j);
        if (t == 0 && i == 0) begin
            case (j % 4)
                0: return 32'h4140_0000;
                1: return 32'h4110_0000;
                2: return 32'h4120_0000;
                default: return 32'h4134_0000;
            endcase
        end
        if (t == 6 && i == 0 && j == 0) return 32'hC000_0000;
        if (t == 6 && i == 0 && j == 1) return 32'h8000_0000;
        return 32'h4000_0000 | (32'(t) << 16) | (32'(i) << 8) | 32'(j);
    endfunction

    function automatic logic [31:0] out_word(input logic [31:0] w);
`ifdef SA_DRAIN_RELU_EN
        return w[31] ? 32'h0 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [W-1:0] exp_row(input int t, input int i);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) r[j*DW +: DW] = out_word(c_word(t, i, j));
        return r;
    endfunction

    task automatic set_tile(input int t);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                c_out_flat[(i*N+j)*DW +: DW] = c_word(t, i, j);
    endtask

    task automatic push_tile(input int t);
        beat_t b;
        for (int i = 0; i < M; i++) begin
            b.data = exp_row(t, i);
            b.idx  = i;
            b.last = (i == M - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_done(input string name, input int limit);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            tick();
            if (drain_done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.row_valid && bus.row_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat_queue_depth", 32'(exp_q.size()), 32'd1);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check_row("beat_data", bus.row_data, e.data);
                check("beat_idx", 32'(bus.row_idx), 32'(e.idx));
                check("beat_last", 32'(bus.row_last), 32'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.row_ready = 1'b1;
        rst_n = 1'b0;
        c_valid_flat = '1;
        set_tile(0);
        repeat (3) tick();
        check("rst_row_valid", 32'(bus.row_valid), 32'd0);
        check("rst_row_idx", 32'(bus.row_idx), 32'd0);
        check("rst_row_last", 32'(bus.row_last), 32'd0);
        check_row("rst_row_data", bus.row_data, '0);
        check("rst_busy", 32'(drain_busy), 32'd0);
        check("rst_done", 32'(drain_done), 32'd0);
        check("rst_overrun", 32'(overrun_err), 32'd0);
        check("rst_tiles", 32'(tiles_drained), 32'd0);
        c_valid_flat = '0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_after_release", 32'(bus.row_valid), 32'd0);

        // Basic drain with row_ready held high
        set_tile(0);
        c_valid_flat = '1;
        push_tile(0);
        tick();
        check("first_beat_valid", 32'(bus.row_valid), 32'd1);
        check("first_beat_idx", 32'(bus.row_idx), 32'd0);
        check("first_beat_busy", 32'(drain_busy), 32'd1);
        set_tile(9);
        repeat (7) tick();
        check("row7_idx", 32'(bus.row_idx), 32'd7);
        check("row7_last", 32'(bus.row_last), 32'd1);
        tick();
        check("basic_done_pulse", 32'(drain_done), 32'd1);
        check("basic_done_valid", 32'(bus.row_valid), 32'd0);
        check("basic_done_busy", 32'(drain_busy), 32'd1);
        check("basic_tiles", 32'(tiles_drained), 32'd1);
        tick();
        check("basic_done_once", 32'(drain_done), 32'd0);
        check("basic_idle_busy", 32'(drain_busy), 32'd0);
        repeat (5) tick();
        check("held_valid_no_redrain", 32'(bus.row_valid), 32'd0);
        check("held_valid_tiles", 32'(tiles_drained), 32'd1);
        check("basic_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure at row 2
        c_valid_flat = '0;
        tick();
        set_tile(1);
        c_valid_flat = '1;
        push_tile(1);
        tick();
        repeat (2) tick();
        bus.row_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", 32'(bus.row_valid), 32'd1);
            check("stall_idx", 32'(bus.row_idx), 32'd2);
            check_row("stall_data", bus.row_data, exp_row(1, 2));
        end
        bus.row_ready = 1'b1;
        wait_done("bp_done", 12);
        check("bp_tiles", 32'(tiles_drained), 32'd2);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Overrun: new tile edge while row 3 is being drained
        c_valid_flat = '0;
        tick();
        set_tile(2);
        c_valid_flat = '1;
        push_tile(2);
        tick();
        repeat (3) tick();
        check("ovr_at_row3", 32'(bus.row_idx), 32'd3);
        c_valid_flat = '0;
        set_tile(3);
        tick();
        c_valid_flat = '1;
        tick();
        check("ovr_set", 32'(overrun_err), 32'd1);
        wait_done("ovr_done", 12);
        check("ovr_sticky", 32'(overrun_err), 32'd1);
        check("ovr_tiles", 32'(tiles_drained), 32'd3);
        check("ovr_queue_empty", 32'(exp_q.size()), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovr_cleared", 32'(overrun_err), 32'd0);

        // Asynchronous reset while row 4 is on the bus
        c_valid_flat = '0;
        tick();
        set_tile(4);
        c_valid_flat = '1;
        push_tile(4);
        tick();
        repeat (4) tick();
        check("mid_at_row4", 32'(bus.row_idx), 32'd4);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.row_valid), 32'd0);
        check("mid_rst_idx", 32'(bus.row_idx), 32'd0);
        check_row("mid_rst_data", bus.row_data, '0);
        check("mid_rst_busy", 32'(drain_busy), 32'd0);
        check("mid_rst_tiles", 32'(tiles_drained), 32'd0);
        exp_q.delete();
        c_valid_flat = '0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(bus.row_valid), 32'd0);
        set_tile(5);
        c_valid_flat = '1;
        push_tile(5);
        wait_done("fresh_done", 12);
        check("fresh_tiles", 32'(tiles_drained), 32'd1);
        check("fresh_queue_empty", 32'(exp_q.size()), 32'd0);

        // Sign-bit words in row 0
        c_valid_flat = '0;
        tick();
        set_tile(6);
        c_valid_flat = '1;
        push_tile(6);
        tick();
`ifdef SA_DRAIN_RELU_EN
        check("relu_w0", bus.row_data[31:0], 32'h0000_0000);
        check("relu_w1", bus.row_data[63:32], 32'h0000_0000);
`else
        check("relu_w0", bus.row_data[31:0], 32'hC000_0000);
        check("relu_w1", bus.row_data[63:32], 32'h8000_0000);
`endif
        wait_done("relu_done", 12);
        check("relu_tiles", 32'(tiles_drained), 32'd2);
        check("relu_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
